// File: rtl/vend_pkg.sv
// Shared types and helpers for the dispenser scheduler.
//   state_e      : FSM state encoding, ST_IDLE..ST_DONE, 3 bits
//   menu_e       : per-front-end menu code, 2 bits
//   next_phase() : phase that follows the current one for a given drink
package vend_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned MENU_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_WATER  = 3'd1,
        ST_COFFEE = 3'd2,
        ST_CREAM  = 3'd3,
        ST_SUGAR  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    typedef enum logic [MENU_W-1:0] {
        MENU_NONE        = 2'b00,
        MENU_BLACK       = 2'b01,
        MENU_CREAM       = 2'b10,
        MENU_CREAM_SUGAR = 2'b11
    } menu_e;

    // Phase order: WATER -> COFFEE -> [CREAM] -> [SUGAR] -> DONE.
    function automatic state_e next_phase(input state_e cur, input menu_e menu);
        state_e nxt;
        nxt = ST_DONE;
        case (cur)
            ST_WATER:  nxt = ST_COFFEE;
            ST_COFFEE: nxt = (menu == MENU_BLACK) ? ST_DONE : ST_CREAM;
            ST_CREAM:  nxt = (menu == MENU_CREAM_SUGAR) ? ST_SUGAR : ST_DONE;
            default:   nxt = ST_DONE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/vend_rr_arbiter.sv
// Combinational rotating-priority picker.
//   req_i   : per-requester request
//   ptr_i   : index of the last winner; search starts at ptr_i+1 and wraps
//   gnt_o   : one-hot winner (combinational)
//   idx_o   : binary index of the winner (combinational)
//   valid_o : some request was found (combinational)
module vend_rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    int unsigned cand;
    logic        found;

    // Walk N_REQ candidates starting after the pointer; first hit wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(ptr_i) + k) % N_REQ;
            if (!found && req_i[IDX_W'(cand)]) begin
                found               = 1'b1;
                gnt_o[IDX_W'(cand)] = 1'b1;
                idx_o               = IDX_W'(cand);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/vend_dispense_sched.sv
// Round-robin scheduler for one shared drink dispenser.
//   Clock, nReset           : clock (rising edge), async active-low reset
//   Req[N_REQ]              : per-front-end request level, held until Done
//   Menu[2*N_REQ]           : per-front-end menu code
//   Abort                   : global emergency stop
//   Grant[N_REQ]            : one-hot dispenser owner
//   Done[N_REQ]             : one-cycle completion pulse to the owner
//   Err                     : one-cycle pulse on empty menu or abort
//   Busy                    : dispenser not idle
//   Water/Coffee/Cream/Sugar: registered valve enables, one per phase
module vend_dispense_sched
    import vend_pkg::*;
#(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned T_WATER  = 4,
    parameter int unsigned T_COFFEE = 2,
    parameter int unsigned T_ADD    = 1,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                    Clock,
    input  logic                    nReset,
    input  logic [N_REQ-1:0]        Req,
    input  logic [MENU_W*N_REQ-1:0] Menu,
    input  logic                    Abort,
    output logic [N_REQ-1:0]        Grant,
    output logic [N_REQ-1:0]        Done,
    output logic                    Err,
    output logic                    Busy,
    output logic                    Water,
    output logic                    Coffee,
    output logic                    Cream,
    output logic                    Sugar
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Counters run T-1 down to 0, so each phase lasts exactly T cycles.
    localparam logic [CNT_W-1:0] LD_WATER  = CNT_W'(T_WATER - 1);
    localparam logic [CNT_W-1:0] LD_COFFEE = CNT_W'(T_COFFEE - 1);
    localparam logic [CNT_W-1:0] LD_ADD    = CNT_W'(T_ADD - 1);

    state_e             state_q;
    menu_e              menu_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [N_REQ-1:0]   grant_q;
    logic [N_REQ-1:0]   done_q;
    logic               err_q;
    logic               busy_q;
    logic               water_q;
    logic               coffee_q;
    logic               cream_q;
    logic               sugar_q;

    logic [N_REQ-1:0]   arb_gnt_c;
    logic [IDX_W-1:0]   arb_idx_c;
    logic               arb_valid_c;
    menu_e              req_menu_c [N_REQ];
    menu_e              sel_menu_c;
    state_e             nxt_phase_c;
    logic [CNT_W-1:0]   nxt_load_c;

    vend_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i   (Req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt_c),
        .idx_o   (arb_idx_c),
        .valid_o (arb_valid_c)
    );

    // Unpack the flat menu bus and pick the arbitration winner's code.
    always_comb begin
        for (int i = 0; i < int'(N_REQ); i++) begin
            req_menu_c[i] = menu_e'(Menu[i*MENU_W +: MENU_W]);
        end
        sel_menu_c = req_menu_c[arb_idx_c];
    end

    // Phase that follows the current one, and its counter preload.
    always_comb begin
        nxt_phase_c = next_phase(state_q, menu_q);
        nxt_load_c  = LD_WATER;
        case (nxt_phase_c)
            ST_COFFEE:          nxt_load_c = LD_COFFEE;
            ST_CREAM, ST_SUGAR: nxt_load_c = LD_ADD;
            default:            nxt_load_c = LD_WATER;
        endcase
    end

    // Scheduler FSM with registered grant, pulse and valve outputs.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= ST_IDLE;
            menu_q   <= MENU_NONE;
            cnt_q    <= '0;
            ptr_q    <= IDX_W'(N_REQ - 1);
            grant_q  <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            water_q  <= 1'b0;
            coffee_q <= 1'b0;
            cream_q  <= 1'b0;
            sugar_q  <= 1'b0;
        end else begin
            done_q <= '0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Abort in idle only blocks arbitration.
                    if (!Abort && arb_valid_c) begin
                        ptr_q <= arb_idx_c;
                        if (sel_menu_c == MENU_NONE) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= ST_WATER;
                            menu_q  <= sel_menu_c;
                            grant_q <= arb_gnt_c;
                            busy_q  <= 1'b1;
                            water_q <= 1'b1;
                            cnt_q   <= LD_WATER;
                        end
                    end
                end
                ST_DONE: begin
                    if (Abort) begin
                        err_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    if (Abort) begin
                        state_q  <= ST_IDLE;
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                        err_q    <= 1'b1;
                        water_q  <= 1'b0;
                        coffee_q <= 1'b0;
                        cream_q  <= 1'b0;
                        sugar_q  <= 1'b0;
                        cnt_q    <= '0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q  <= nxt_phase_c;
                        cnt_q    <= nxt_load_c;
                        water_q  <= 1'b0;
                        coffee_q <= (nxt_phase_c == ST_COFFEE);
                        cream_q  <= (nxt_phase_c == ST_CREAM);
                        sugar_q  <= (nxt_phase_c == ST_SUGAR);
                        if (nxt_phase_c == ST_DONE) begin
                            done_q <= grant_q;
                        end
                    end
                end
            endcase
        end
    end

    assign Grant  = grant_q;
    assign Done   = done_q;
    assign Err    = err_q;
    assign Busy   = busy_q;
    assign Water  = water_q;
    assign Coffee = coffee_q;
    assign Cream  = cream_q;
    assign Sugar  = sugar_q;

endmodule

// File: tb/tb_vend_dispense_sched.sv
// Directed self-checking bench for vend_dispense_sched (default parameters).
module tb_vend_dispense_sched;

    logic       Clock = 1'b0;
    logic       nReset = 1'b0;
    logic [1:0] Req = '0;
    logic [3:0] Menu = '0;
    logic       Abort = 1'b0;
    logic [1:0] Grant;
    logic [1:0] Done;
    logic       Err;
    logic       Busy;
    logic       Water;
    logic       Coffee;
    logic       Cream;
    logic       Sugar;

    int checks = 0;
    int errors = 0;

    vend_dispense_sched #(
        .N_REQ    (2),
        .T_WATER  (4),
        .T_COFFEE (2),
        .T_ADD    (1),
        .CNT_W    (4)
    ) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .Req    (Req),
        .Menu   (Menu),
        .Abort  (Abort),
        .Grant  (Grant),
        .Done   (Done),
        .Err    (Err),
        .Busy   (Busy),
        .Water  (Water),
        .Coffee (Coffee),
        .Cream  (Cream),
        .Sugar  (Sugar)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic apply_reset();
        nReset = 1'b0;
        Req    = '0;
        Menu   = '0;
        Abort  = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        nReset = 1'b1;
    endtask

    // Runs until the current grant ends (or 40 cycles), tallying what was seen.
    // The owner drops its Req when it sees Done.
    task automatic measure(output int lat, output logic [1:0] first_g,
                           output int nw, output int nc, output int ncr,
                           output int ns, output int ng, output logic [1:0] dmask,
                           output int nd, output int nerr, output int nbad,
                           output bit fin);
        lat = -1; first_g = '0; nw = 0; nc = 0; ncr = 0; ns = 0; ng = 0;
        dmask = '0; nd = 0; nerr = 0; nbad = 0; fin = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (Grant == 2'b11) nbad++;
            if (int'(Water) + int'(Coffee) + int'(Cream) + int'(Sugar) > 1) nbad++;
            if (Grant == 2'b00 && (Water | Coffee | Cream | Sugar)) nbad++;
            if (Grant != 2'b00 && lat < 0) begin
                lat     = k;
                first_g = Grant;
            end
            if (Grant != 2'b00) ng++;
            nw   += int'(Water);
            nc   += int'(Coffee);
            ncr  += int'(Cream);
            ns   += int'(Sugar);
            nerr += int'(Err);
            if (Done != 2'b00) begin
                nd++;
                dmask |= Done;
                if ((Done & ~Grant) != 2'b00) nbad++;
                Req = Req & ~Done;
            end
            if (lat >= 0 && Grant == 2'b00) begin
                fin = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        #12;
        checks++;
        if ({Grant, Done, Err, Busy, Water, Coffee, Cream, Sugar} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 000",
                     {Grant, Done, Err, Busy, Water, Coffee, Cream, Sugar});
        end
    endtask

    task automatic test_black();
        int lat, nw, nc, ncr, ns, ng, nd, nerr, nbad;
        logic [1:0] fg, dm;
        bit fin;
        apply_reset();
        Req = 2'b01; Menu = 4'b0001;
        measure(lat, fg, nw, nc, ncr, ns, ng, dm, nd, nerr, nbad, fin);
        checks++;
        if (!fin || lat !== 0 || fg !== 2'b01) begin
            errors++;
            $display("FAIL black_grant: fin=%0d lat=%0d grant=%b expected fin=1 lat=0 grant=01", fin, lat, fg);
        end
        checks++;
        if (nw !== 4 || nc !== 2 || ncr !== 0 || ns !== 0) begin
            errors++;
            $display("FAIL black_valves: w=%0d c=%0d cr=%0d s=%0d expected 4 2 0 0", nw, nc, ncr, ns);
        end
        checks++;
        if (ng !== 7 || nd !== 1 || dm !== 2'b01 || nbad !== 0 || nerr !== 0) begin
            errors++;
            $display("FAIL black_grant_done: grant_w=%0d nd=%0d dm=%b bad=%0d err=%0d expected 7 1 01 0 0",
                     ng, nd, dm, nbad, nerr);
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL black_idle_busy: got %b expected 0", Busy);
        end
    endtask

    task automatic test_cream_sugar();
        int lat, nw, nc, ncr, ns, ng, nd, nerr, nbad;
        logic [1:0] fg, dm;
        bit fin;
        apply_reset();
        Req = 2'b10; Menu = 4'b1100;
        measure(lat, fg, nw, nc, ncr, ns, ng, dm, nd, nerr, nbad, fin);
        checks++;
        if (!fin || lat !== 0 || fg !== 2'b10) begin
            errors++;
            $display("FAIL cs_grant: fin=%0d lat=%0d grant=%b expected fin=1 lat=0 grant=10", fin, lat, fg);
        end
        checks++;
        if (nw !== 4 || nc !== 2 || ncr !== 1 || ns !== 1) begin
            errors++;
            $display("FAIL cs_valves: w=%0d c=%0d cr=%0d s=%0d expected 4 2 1 1", nw, nc, ncr, ns);
        end
        checks++;
        if (ng !== 9 || nd !== 1 || dm !== 2'b10 || nbad !== 0) begin
            errors++;
            $display("FAIL cs_grant_done: grant_w=%0d nd=%0d dm=%b bad=%0d expected 9 1 10 0", ng, nd, dm, nbad);
        end
    endtask

    task automatic test_menu_latch();
        int lat, nw, nc, ncr, ns, ng, nd, nerr, nbad;
        logic [1:0] fg, dm;
        bit fin;
        apply_reset();
        Req = 2'b01; Menu = 4'b0011;
        step();
        checks++;
        if (Grant !== 2'b01 || Water !== 1'b1) begin
            errors++;
            $display("FAIL latch_start: grant=%b water=%b expected 01 1", Grant, Water);
        end
        Menu = 4'b0001;
        measure(lat, fg, nw, nc, ncr, ns, ng, dm, nd, nerr, nbad, fin);
        checks++;
        if (!fin || nw !== 3 || nc !== 2 || ncr !== 1 || ns !== 1 || ng !== 8 || dm !== 2'b01) begin
            errors++;
            $display("FAIL latch_menu: fin=%0d w=%0d c=%0d cr=%0d s=%0d gw=%0d dm=%b expected 1 3 2 1 1 8 01",
                     fin, nw, nc, ncr, ns, ng, dm);
        end
    endtask

    task automatic test_back_to_back();
        int order[4];
        int gaps[4];
        int n, idle_run, bad;
        logic [1:0] prev;
        apply_reset();
        Req = 2'b11; Menu = 4'b0101;
        n = 0; idle_run = 0; bad = 0; prev = 2'b00;
        for (int i = 0; i < 4; i++) begin
            order[i] = -1;
            gaps[i]  = -1;
        end
        for (int k = 0; k < 60 && n < 4; k++) begin
            step();
            if (Grant == 2'b11) bad++;
            if (Grant != 2'b00 && prev == 2'b00) begin
                order[n] = (Grant == 2'b01) ? 0 : 1;
                gaps[n]  = idle_run;
                n++;
            end
            if (Grant == 2'b00) idle_run++;
            else idle_run = 0;
            prev = Grant;
        end
        checks++;
        if (n !== 4 || order[0] !== 0 || order[1] !== 1 || order[2] !== 0 || order[3] !== 1) begin
            errors++;
            $display("FAIL b2b_order: n=%0d order=%0d,%0d,%0d,%0d expected 4 0,1,0,1",
                     n, order[0], order[1], order[2], order[3]);
        end
        checks++;
        if (gaps[1] !== 1 || gaps[2] !== 1 || gaps[3] !== 1 || bad !== 0) begin
            errors++;
            $display("FAIL b2b_gaps: gaps=%0d,%0d,%0d both_granted=%0d expected 1,1,1 0",
                     gaps[1], gaps[2], gaps[3], bad);
        end
    endtask

    task automatic test_invalid_menu();
        int lat, nw, nc, ncr, ns, ng, nd, nerr, nbad;
        logic [1:0] fg, dm;
        bit fin;
        apply_reset();
        Req = 2'b11; Menu = 4'b1000;
        step();
        checks++;
        if (Err !== 1'b1 || Grant !== 2'b00 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL inv_err: err=%b grant=%b busy=%b expected 1 00 0", Err, Grant, Busy);
        end
        Req = 2'b10;
        measure(lat, fg, nw, nc, ncr, ns, ng, dm, nd, nerr, nbad, fin);
        checks++;
        if (!fin || lat !== 0 || fg !== 2'b10 || nerr !== 0) begin
            errors++;
            $display("FAIL inv_next_grant: fin=%0d lat=%0d grant=%b err=%0d expected 1 0 10 0", fin, lat, fg, nerr);
        end
        checks++;
        if (nw !== 4 || nc !== 2 || ncr !== 1 || ns !== 0 || ng !== 8 || dm !== 2'b10 || nbad !== 0) begin
            errors++;
            $display("FAIL inv_cream_seq: w=%0d c=%0d cr=%0d s=%0d gw=%0d dm=%b bad=%0d expected 4 2 1 0 8 10 0",
                     nw, nc, ncr, ns, ng, dm, nbad);
        end
    endtask

    task automatic test_abort();
        int lat, nw, nc, ncr, ns, ng, nd, nerr, nbad;
        logic [1:0] fg, dm;
        bit fin;
        bit seen;
        apply_reset();
        Req = 2'b01; Menu = 4'b0001;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            if (Coffee) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL abort_wait_coffee: coffee never rose within 10 cycles");
        end
        step();
        checks++;
        if (Coffee !== 1'b1) begin
            errors++;
            $display("FAIL abort_coffee2: got %b expected 1", Coffee);
        end
        Abort = 1'b1;
        step();
        checks++;
        if ({Water, Coffee, Cream, Sugar} !== 4'b0000 || Grant !== 2'b00 || Err !== 1'b1 ||
            Done !== 2'b00 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_stop: valves=%b grant=%b err=%b done=%b busy=%b expected 0000 00 1 00 0",
                     {Water, Coffee, Cream, Sugar}, Grant, Err, Done, Busy);
        end
        step();
        checks++;
        if (Err !== 1'b0 || Grant !== 2'b00 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: err=%b grant=%b busy=%b expected 0 00 0", Err, Grant, Busy);
        end
        Abort = 1'b0;
        measure(lat, fg, nw, nc, ncr, ns, ng, dm, nd, nerr, nbad, fin);
        checks++;
        if (!fin || lat !== 0 || fg !== 2'b01 || ng !== 7 || dm !== 2'b01) begin
            errors++;
            $display("FAIL abort_resume: fin=%0d lat=%0d grant=%b gw=%0d dm=%b expected 1 0 01 7 01",
                     fin, lat, fg, ng, dm);
        end
    endtask

    task automatic test_async_reset();
        int lat, nw, nc, ncr, ns, ng, nd, nerr, nbad;
        logic [1:0] fg, dm;
        bit fin;
        apply_reset();
        Req = 2'b11; Menu = 4'b0101;
        step();
        step();
        checks++;
        if (Water !== 1'b1 || Grant !== 2'b01) begin
            errors++;
            $display("FAIL arst_pre: water=%b grant=%b expected 1 01", Water, Grant);
        end
        #1 nReset = 1'b0;
        #1;
        checks++;
        if (Water !== 1'b0 || Grant !== 2'b00 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate: water=%b grant=%b busy=%b expected 0 00 0", Water, Grant, Busy);
        end
        @(negedge Clock);
        nReset = 1'b1;
        measure(lat, fg, nw, nc, ncr, ns, ng, dm, nd, nerr, nbad, fin);
        checks++;
        if (!fin || lat !== 0 || fg !== 2'b01 || dm !== 2'b01) begin
            errors++;
            $display("FAIL arst_rr_restart: fin=%0d lat=%0d grant=%b dm=%b expected 1 0 01 01", fin, lat, fg, dm);
        end
    endtask

    initial begin
        test_reset();
        test_black();
        test_cream_sugar();
        test_menu_latch();
        test_back_to_back();
        test_invalid_menu();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
